pdm_word_buffer: RTL

// - Downstream of the PDM deserializer. Captures each 16-bit word, qualified by the deserializer's one-cycle done strobe, into on-chip memory.
// - Later streams the stored words back out, oldest first, over a valid/ready port for playback/export.
// - Runs on the 100 MHz system clock; input words arrive at most once per 16 cycles.

---
 rtl/pdm_word_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pdm_word_buffer.sv
// pdm_word_buffer
//   Captures 16-bit words from the PDM deserializer into on-chip memory while
//   'record' is high. On request, it streams the stored words back out, oldest
//   first, over a valid/ready port. Readout is non-destructive.
//
//   Build option: define PDM_BUF_OVERWRITE_EN for ring capture. The newest
//   DEPTH words are kept and the FULL state is never entered. Without the
//   macro, capture is linear: the first DEPTH words are kept.
//
// Ports
//   clock       system clock (100 MHz)
//   reset       synchronous, active-high
//   record      level; high = capture incoming words
//   word_valid  one-cycle strobe qualifying word_in
//   word_in     deserializer data word
//   rd_start    one-cycle pulse; begin readout of stored words
//   rd_ready    consumer accepts rd_data this cycle
//   rd_valid    rd_data holds a valid word
//   rd_data     stored word, oldest first
//   count       number of words held, 0..DEPTH
//   full        count == DEPTH
//   overrun     sticky; a word was dropped or overwritten
//   state_o     IDLE=0, RECORD=1, FULL=2, READOUT=3

module pdm_word_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     record,
    input  logic                     word_valid,
    input  logic [WIDTH-1:0]         word_in,
    input  logic                     rd_start,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    output logic [1:0]               state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECORD  = 2'd1,
        ST_FULL    = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, base_q;
    logic [CW-1:0]    count_q, remain_q;
    logic             overrun_q, rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic          at_cap;
    logic          mem_we;
    logic [AW-1:0] wr_ptr_d;

    assign at_cap   = (count_q == CNT_MAX);
    assign wr_ptr_d = wr_ptr_q + AW'(1);
    // In linear mode the FSM leaves RECORD at DEPTH, so every RECORD strobe
    // is a legal write. In ring mode a write at capacity is the overwrite.
    assign mem_we   = !reset && (state_q == ST_RECORD) && word_valid;

    // Storage is not reset; 'count' alone defines which entries are meaningful.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            base_q     <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (record) begin
                        state_q   <= ST_RECORD;
                        wr_ptr_q  <= '0;
                        base_q    <= '0;
                        count_q   <= '0;
                        overrun_q <= 1'b0;
                    end else if (rd_start && (count_q != '0)) begin
                        state_q  <= ST_READOUT;
                        rd_ptr_q <= base_q;
                        remain_q <= count_q;
                    end
                end

                ST_RECORD: begin
                    if (word_valid) begin
                        wr_ptr_q <= wr_ptr_d;
`ifdef PDM_BUF_OVERWRITE_EN
                        // At capacity the oldest word is replaced, so the
                        // oldest-word pointer moves with the write pointer.
                        if (at_cap) begin
                            base_q    <= base_q + AW'(1);
                            overrun_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
`else
                        count_q <= count_q + CW'(1);
`endif
                    end
                    if (!record) begin
                        state_q <= ST_IDLE;
                    end
`ifdef PDM_BUF_OVERWRITE_EN
`else
                    else if (word_valid && (count_q == CNT_LAST)) begin
                        state_q <= ST_FULL;
                    end
`endif
                end

                ST_FULL: begin
                    if (word_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (rd_start) begin
                        state_q  <= ST_READOUT;
                        rd_ptr_q <= base_q;
                        remain_q <= count_q;
                    end else if (!record) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_READOUT: begin
                    // Alternates fetch and present phases. The cycle after a
                    // handshake performs the next fetch, so rd_valid is low
                    // for that one cycle.
                    if (!rd_valid_q) begin
                        rd_data_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q   <= rd_ptr_q + AW'(1);
                        rd_valid_q <= 1'b1;
                    end else if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        remain_q   <= remain_q - CW'(1);
                        if (remain_q == CW'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign full     = at_cap;
    assign overrun  = overrun_q;
    assign state_o  = state_q;

endmodule
